mantissa_align: RTL and testbench

MANTISSA_ALIGN -- requirements
Module: mantissa_align

---
 rtl/mantissa_align.sv | 116 +++++++++++
 tb/tb_mantissa_align.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_align.sv
// Right-shift alignment of the smaller-exponent mantissa for FP add.
// Produces guard/round/sticky below the aligned mantissa LSB.
module mantissa_align #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  exp_diff,
  input  logic              borrow,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] big_mant,
  output logic [MANT_W-1:0] small_mant,
  output logic              guard,
  output logic              round_b,
  output logic              sticky
);

  localparam int unsigned WW = MANT_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [MANT_W+1:0] r_w;
  logic              r_s;
  logic [EXP_W-1:0]  r_cnt;
  logic [MANT_W-1:0] r_big;
  logic [EXP_W-1:0]  r_exp;

  logic              w_xfer;
  logic              w_clamp;
  logic              w_zero;
  logic [MANT_W-1:0] w_small;
  logic [MANT_W-1:0] w_big;
  logic [EXP_W-1:0]  w_exp;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_xfer    = in_valid & in_ready;
  assign w_small   = borrow ? mant_a : mant_b;
  assign w_big     = borrow ? mant_b : mant_a;
  assign w_exp     = borrow ? exp_b : exp_a;
  assign w_clamp   = 32'(exp_diff) >= 32'(WW);
  assign w_zero    = (exp_diff == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_xfer)
          w_next = (w_clamp || w_zero) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (r_cnt == EXP_W'(1)) w_next = DONE;
      end
      DONE: begin
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Shifting is serial; a huge difference collapses straight into sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w   <= '0;
      r_s   <= 1'b0;
      r_cnt <= '0;
      r_big <= '0;
      r_exp <= '0;
    end else if (r_state == IDLE && w_xfer) begin
      r_big <= w_big;
      r_exp <= w_exp;
      if (w_clamp) begin
        r_w   <= '0;
        r_s   <= |w_small;
        r_cnt <= '0;
      end else begin
        r_w   <= {w_small, 2'b00};
        r_s   <= 1'b0;
        r_cnt <= exp_diff;
      end
    end else if (r_state == SHIFT) begin
      r_s   <= r_s | r_w[0];
      r_w   <= r_w >> 1;
      r_cnt <= r_cnt - EXP_W'(1);
    end
  end

  assign exp_out    = r_exp;
  assign big_mant   = r_big;
  assign small_mant = r_w[MANT_W+1:2];
  assign guard      = r_w[1];
  assign round_b    = r_w[0];
  assign sticky     = r_s;

endmodule

// File: tb/tb_mantissa_align.sv
// Self-checking bench for mantissa_align: vector table, random
// traffic against an arithmetic model, backpressure and reset cases.
module tb_mantissa_align;

  localparam int MW = 24;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] exp_diff;
  logic          borrow;
  logic [EW-1:0] exp_a;
  logic [EW-1:0] exp_b;
  logic [MW-1:0] mant_a;
  logic [MW-1:0] mant_b;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] exp_out;
  logic [MW-1:0] big_mant;
  logic [MW-1:0] small_mant;
  logic          guard;
  logic          round_b;
  logic          sticky;

  int total = 0;
  int bad   = 0;

  mantissa_align #(.MANT_W(MW), .EXP_W(EW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .exp_diff(exp_diff), .borrow(borrow),
    .exp_a(exp_a), .exp_b(exp_b),
    .mant_a(mant_a), .mant_b(mant_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .big_mant(big_mant),
    .small_mant(small_mant), .guard(guard),
    .round_b(round_b), .sticky(sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            d;
    logic          b;
    logic [EW-1:0] ea;
    logic [EW-1:0] eb;
    logic [MW-1:0] ma;
    logic [MW-1:0] mb;
    logic [MW-1:0] sm;
    logic          g;
    logic          r;
    logic          s;
    logic [EW-1:0] eo;
    logic [MW-1:0] big;
    int            lat;
  } vec_t;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: shift the widened small mantissa as a plain number.
  function automatic vec_t model(input int d, input logic b,
      input logic [EW-1:0] ea, input logic [EW-1:0] eb,
      input logic [MW-1:0] ma, input logic [MW-1:0] mb);
    vec_t v;
    longint unsigned x, w, lost;
    logic [MW-1:0] sm;
    v.d = d; v.b = b; v.ea = ea; v.eb = eb; v.ma = ma; v.mb = mb;
    sm    = b ? ma : mb;
    v.big = b ? mb : ma;
    v.eo  = b ? eb : ea;
    x = longint'(sm) * 4;
    if (d >= MW + 2) begin
      w    = 0;
      lost = x;
      v.lat = 1;
    end else begin
      w    = x >> d;
      lost = x & ((64'd1 << d) - 1);
      v.lat = d + 1;
    end
    v.sm = MW'(w >> 2);
    v.g  = w[1];
    v.r  = w[0];
    v.s  = (lost != 0);
    return v;
  endfunction

  task automatic scramble();
    exp_diff = EW'($urandom);
    borrow   = 1'($urandom);
    exp_a    = EW'($urandom);
    exp_b    = EW'($urandom);
    mant_a   = MW'($urandom);
    mant_b   = MW'($urandom);
  endtask

  task automatic chk_out(input string nm, input vec_t v);
    chk({nm, " small"}, longint'(small_mant), longint'(v.sm));
    chk({nm, " grs"}, longint'({guard, round_b, sticky}),
        longint'({v.g, v.r, v.s}));
    chk({nm, " exp"}, longint'(exp_out), longint'(v.eo));
    chk({nm, " big"}, longint'(big_mant), longint'(v.big));
  endtask

  // Called at posedge+1 in IDLE; leaves the DUT back in IDLE.
  task automatic run(input string nm, input vec_t v, input int hold);
    int lat;
    chk({nm, " in_ready"}, longint'(in_ready), 1);
    exp_diff = EW'(v.d); borrow = v.b;
    exp_a = v.ea; exp_b = v.eb;
    mant_a = v.ma; mant_b = v.mb;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      scramble();
    end
    chk({nm, " latency"}, longint'(lat), longint'(v.lat));
    chk_out(nm, v);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      scramble();
      chk({nm, " hold valid"}, longint'({out_valid, in_ready}), 2);
      chk_out({nm, " hold"}, v);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " release"}, longint'({out_valid, in_ready}), 1);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    int d;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    exp_diff = '0; borrow = 1'b0; exp_a = '0; exp_b = '0;
    mant_a = '0; mant_b = '0;

    tbl[0] = '{0,   1'b0, 8'h80, 8'h80, 24'h800000, 24'hC00000,
               24'hC00000, 1'b0, 1'b0, 1'b0, 8'h80, 24'h800000, 1};
    tbl[1] = '{3,   1'b0, 8'h90, 8'h8D, 24'hFFFFFF, 24'hC00001,
               24'h180000, 1'b0, 1'b0, 1'b1, 8'h90, 24'hFFFFFF, 4};
    tbl[2] = '{1,   1'b1, 8'h84, 8'h85, 24'h800001, 24'hABCDEF,
               24'h400000, 1'b1, 1'b0, 1'b0, 8'h85, 24'hABCDEF, 2};
    tbl[3] = '{200, 1'b0, 8'h10, 8'h00, 24'h123456, 24'h000001,
               24'h000000, 1'b0, 1'b0, 1'b1, 8'h10, 24'h123456, 1};
    tbl[4] = '{26,  1'b0, 8'h40, 8'h26, 24'h900000, 24'h800000,
               24'h000000, 1'b0, 1'b0, 1'b1, 8'h40, 24'h900000, 1};
    tbl[5] = '{25,  1'b0, 8'h40, 8'h27, 24'h900000, 24'h800000,
               24'h000000, 1'b0, 1'b1, 1'b0, 8'h40, 24'h900000, 26};
    tbl[6] = '{24,  1'b0, 8'h40, 8'h28, 24'h900000, 24'hC00000,
               24'h000000, 1'b1, 1'b1, 1'b0, 8'h40, 24'h900000, 25};
    tbl[7] = '{30,  1'b1, 8'h02, 8'h20, 24'h000000, 24'hFFFFFF,
               24'h000000, 1'b0, 1'b0, 1'b0, 8'h20, 24'hFFFFFF, 1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset hs", longint'({out_valid, in_ready}), 1);
    chk("reset small", longint'(small_mant), 0);
    chk("reset big", longint'(big_mant), 0);
    chk("reset exp", longint'(exp_out), 0);
    chk("reset grs", longint'({guard, round_b, sticky}), 0);

    foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i], i % 3);

    // long backpressure stall
    v = model(5, 1'b0, 8'h33, 8'h2E, 24'hABCDEF, 24'hFEDCBA);
    run("bp", v, 5);

    // reset in the middle of a 20-step shift
    exp_diff = 8'd20; borrow = 1'b0; mant_b = 24'hFFFFFF;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid shift", longint'({out_valid, in_ready}), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid rst hs", longint'({out_valid, in_ready}), 1);
    chk("mid rst small", longint'(small_mant), 0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid rst no out", longint'(seen), 0);

    for (int n = 0; n < 40; n++) begin
      d = (n % 5 == 0) ? int'($urandom_range(0, 255))
                       : int'($urandom_range(0, 28));
      v = model(d, 1'($urandom), EW'($urandom), EW'($urandom),
                MW'($urandom), MW'($urandom));
      run($sformatf("rnd%0d", n), v, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
